serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: diff = a - b - b_in, one bit per clock, LSB first.
//   Complements the combinational adder library (ripple / carry-skip / square-root adders).
//   Provides the low-area subtract path for the datapath, with a start/busy/done handshake.
//   Results are registered and held until the next operation completes.
// PARAMETERS
//   N      16    operand / result width in bits (N >= 2)
//   CW     5     bit-counter width, ceil(log2(N))+1
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   reset, asynchronous, active-low
//   start   in   1   request; sampled only in IDLE or DONE
//   a       in   N   minuend, captured on accepted start
//   b       in   N   subtrahend, captured on accepted start
//   b_in    in   1   borrow in, captured on accepted start
//   busy    out  1   high while in SHIFT
//   done    out  1   one-cycle pulse, results valid
//   diff    out  N   a - b - b_in, modulo 2^N
//   b_out   out  1   final borrow (1 = unsigned a < b + b_in)
//   ovf     out  1   signed overflow
//   zero    out  1   diff == 0
// BEHAVIOUR
//   - Reset (rst_n=0, any time, including mid-operation):
//     state=IDLE; busy, done, diff, b_out, ovf, zero = 0; shift registers and counter cleared.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE --start--> SHIFT.
//     SHIFT --N bits processed--> DONE.
//     DONE --start--> SHIFT (back-to-back); DONE --!start--> IDLE.
//   - Accept edge E0 (start=1 in IDLE or DONE):
//     latch a, b; borrow register br = b_in; count = 0; busy = 1.
//   - Edges E1..EN, one bit per edge, using the LSB of each shift register:
//     d = a0 ^ b0 ^ br;  br' = (~a0 & b0) | (~(a0 ^ b0) & br).
//     Shift d into the MSB of the internal result register; shift a and b right by one.
//   - At EN:
//     diff = result; b_out = br'; zero = (result == 0);
//     ovf = (a[N-1] != b[N-1]) & (diff[N-1] != a[N-1]), using the latched operands.
//     State goes to DONE; busy = 0; done = 1 for exactly one cycle.
//   - Latency: done is high in the cycle following edge EN, which is N edges after the accept edge.
//     Throughput is one result every N+1 cycles when start is held high.
//   - start during SHIFT is ignored; it is not queued and operands are not re-latched.
//   - a, b and b_in may change freely after the accept edge without affecting the result.
//   - diff, b_out, ovf and zero change only at EN and hold through IDLE and through the next SHIFT.
//   - Wrap-around: the result is modulo 2^N. Borrow out of the MSB appears only on b_out.
//   - busy and done are never high together.
// TESTING  (N=8)
//   1 a=0x5A b=0x3C b_in=0, pulse start -> after 8 edges done=1:
//     diff=0x1E, b_out=0, ovf=0, zero=0.
//   2 a=0x00 b=0x01 b_in=0 -> diff=0xFF, b_out=1, ovf=0.
//     a=0x80 b=0x01 -> diff=0x7F, ovf=1, b_out=0.
//   3 a=0x10 b=0x0F b_in=1 -> diff=0x00, zero=1, b_out=0.
//     a=0x33 b=0x33 b_in=1 -> diff=0xFF, b_out=1.
//   4 start=1 held: 3 ops 0x05-0x02, 0x02-0x05, 0x7F-0xFF ->
//     done pulses every 9 cycles; diff = 0x03, 0xFD, 0x80; third op ovf=1.
//   5 start pulsed with new operands at edge E4 of an op -> ignored:
//     first result unchanged; no second done.
//   6 rst_n=0 at E5 mid-op -> all outputs 0 immediately (async), IDLE.
//     After release, fresh start 0x09-0x04 -> diff=0x05.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives start, a, b, b_in; observes busy, done, diff, b_out, ovf, zero
//   slave  : the subtractor side of the same signals
interface serial_subtractor_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
  logic         ovf;
  logic         zero;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf, zero
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in (mod 2^N),
// one bit per clock, LSB first, with a start/busy/done handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start, a, b, b_in in;
//           busy, done, diff, b_out, ovf, zero out)
// Results are registered and held until the next operation completes.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | processing one bit per clock, busy high
// DONE  | one-cycle done pulse; start here begins the next op
module serial_subtractor #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  res;
  logic          br;
  logic [CW-1:0] count;
  // Operand sign bits are kept aside because the shift registers lose them.
  logic          a_msb;
  logic          b_msb;

  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  diff_r;
  logic          b_out_r;
  logic          ovf_r;
  logic          zero_r;

  logic          d;
  logic          br_nxt;
  logic [N-1:0]  res_nxt;

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_nxt = {d, res[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      br      <= 1'b0;
      count   <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= '0;
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= SHIFT;
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.b_in;
            a_msb  <= bus.a[N-1];
            b_msb  <= bus.b[N-1];
            count  <= '0;
            busy_r <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          br    <= br_nxt;
          res   <= res_nxt;
          count <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            state   <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            diff_r  <= res_nxt;
            b_out_r <= br_nxt;
            zero_r  <= (res_nxt == '0);
            // d is the MSB of the final result.
            ovf_r   <= (a_msb != b_msb) & (d != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.diff  = diff_r;
  assign bus.b_out = b_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.zero  = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at N=8.
module tb_serial_subtractor;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands and a one-cycle start pulse; return the number of
  // negedges from the accept edge until done is seen (bounded).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin, output int cycles);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.b_in = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble the inputs: they must not affect the running operation.
    bus.a = ~a; bus.b = ~b; bus.b_in = ~bin;
    cycles = 1;
    while (!bus.done && cycles < 20) begin
      checks++;
      if (bus.busy && bus.done) begin
        fails++;
        $display("FAIL busy_done_overlap busy=%b done=%b required not both", bus.busy, bus.done);
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.b_out, bus.ovf, bus.zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h b_out=%b ovf=%b zero=%b required all 0",
               bus.busy, bus.done, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic;
    int cyc;
    run_op(8'h5A, 8'h3C, 1'b0, cyc);
    checks++;
    if (cyc !== N + 1) begin
      fails++; $display("FAIL basic_latency got %0d required %0d", cyc, N + 1);
    end
    checks++;
    if ({bus.diff, bus.b_out, bus.ovf, bus.zero} !== {8'h1E, 3'b000}) begin
      fails++;
      $display("FAIL basic_result got diff=%h b_out=%b ovf=%b zero=%b required 1e 0 0 0",
               bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      fails++; $display("FAIL done_one_cycle got %b required 0", bus.done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.diff !== 8'h1E || bus.busy !== 1'b0) begin
      fails++; $display("FAIL hold_in_idle got diff=%h busy=%b required 1e 0", bus.diff, bus.busy);
    end
  endtask

  task automatic test_borrow;
    int cyc;
    run_op(8'h00, 8'h01, 1'b0, cyc);
    checks++;
    if (cyc !== N + 1 || {bus.diff, bus.b_out, bus.ovf, bus.zero} !== {8'hFF, 3'b100}) begin
      fails++;
      $display("FAIL borrow_wrap got cyc=%0d diff=%h b_out=%b ovf=%b zero=%b required 9 ff 1 0 0",
               cyc, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
    run_op(8'h80, 8'h01, 1'b0, cyc);
    checks++;
    if (cyc !== N + 1 || {bus.diff, bus.b_out, bus.ovf, bus.zero} !== {8'h7F, 3'b010}) begin
      fails++;
      $display("FAIL signed_ovf got cyc=%0d diff=%h b_out=%b ovf=%b zero=%b required 9 7f 0 1 0",
               cyc, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
  endtask

  task automatic test_borrow_in;
    int cyc;
    run_op(8'h10, 8'h0F, 1'b1, cyc);
    checks++;
    if (cyc !== N + 1 || {bus.diff, bus.b_out, bus.ovf, bus.zero} !== {8'h00, 3'b001}) begin
      fails++;
      $display("FAIL bin_zero got cyc=%0d diff=%h b_out=%b ovf=%b zero=%b required 9 00 0 0 1",
               cyc, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
    run_op(8'h33, 8'h33, 1'b1, cyc);
    checks++;
    if (cyc !== N + 1 || {bus.diff, bus.b_out, bus.ovf, bus.zero} !== {8'hFF, 3'b100}) begin
      fails++;
      $display("FAIL bin_equal got cyc=%0d diff=%h b_out=%b ovf=%b zero=%b required 9 ff 1 0 0",
               cyc, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] op_a [3];
    logic [N-1:0] op_b [3];
    logic [N-1:0] exp_d [3];
    logic [2:0]   exp_f [3];
    int cyc;
    op_a = '{8'h05, 8'h02, 8'h7F};
    op_b = '{8'h02, 8'h05, 8'hFF};
    exp_d = '{8'h03, 8'hFD, 8'h80};
    exp_f = '{3'b000, 3'b100, 3'b110};   // {b_out, ovf, zero}
    @(negedge clk);
    bus.a = op_a[0]; bus.b = op_b[0]; bus.b_in = 1'b0; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) begin
        bus.a = op_a[k+1]; bus.b = op_b[k+1];
      end else begin
        bus.start = 1'b0;
      end
      cyc = 1;
      while (!bus.done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc !== N + 1 || bus.diff !== exp_d[k] || {bus.b_out, bus.ovf, bus.zero} !== exp_f[k]) begin
        fails++;
        $display("FAIL b2b_op%0d got cyc=%0d diff=%h flags=%b required 9 %h %b",
                 k, cyc, bus.diff, {bus.b_out, bus.ovf, bus.zero}, exp_d[k], exp_f[k]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL b2b_return_idle got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    @(negedge clk);
    bus.a = 8'h20; bus.b = 8'h01; bus.b_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);                      // accept edge E0 has passed
    bus.start = 1'b0;
    repeat (3) @(negedge clk);           // E1..E3 have passed
    bus.a = 8'h77; bus.b = 8'h11; bus.b_in = 1'b1; bus.start = 1'b1;
    @(negedge clk);                      // E4 samples start during SHIFT
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      if (dones == 1 && bus.done) begin
        checks++;
        if (bus.diff !== 8'h1F || bus.b_out !== 1'b0) begin
          fails++;
          $display("FAIL ignore_first_result got diff=%h b_out=%b required 1f 0", bus.diff, bus.b_out);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      fails++; $display("FAIL ignore_no_second_done got %0d done pulses required 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    bus.a = 8'h55; bus.b = 8'h11; bus.b_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);                      // E5
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.b_out, bus.ovf, bus.zero} !== '0) begin
      fails++;
      $display("FAIL async_reset got busy=%b done=%b diff=%h b_out=%b ovf=%b zero=%b required all 0",
               bus.busy, bus.done, bus.diff, bus.b_out, bus.ovf, bus.zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL reset_no_resume got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    run_op(8'h09, 8'h04, 1'b0, cyc);
    checks++;
    if (cyc !== N + 1 || bus.diff !== 8'h05 || bus.b_out !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_op got cyc=%0d diff=%h b_out=%b required 9 05 0", cyc, bus.diff, bus.b_out);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_borrow_in();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
